// File: rtl/gate_truth_checker.sv
// gate_truth_checker
// Stimulus/response engine that sweeps every input combination of a logic
// gate, holds each vector for a settle time, samples the gate output and
// compares it against the golden function selected by GATE_OP.
//
// Parameters:
//   N_IN        gate input count, V = 2**N_IN vectors (1..6)
//   SETTLE_CYC  cycles each vector is held before sampling (>=1)
//   GATE_OP     golden fn: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR,
//               anything else compares against constant 0
//
// Ports:
//   clk, rst    clock (rising edge), async active-high reset
//   start       begin a sweep; only looked at in IDLE or DONE
//   stim        gate inputs (stim[0] = A, stim[1] = B, ...)
//   dut_y       gate-under-test output
//   busy        high while settling/sampling
//   done        sweep complete, held until the next accepted start
//   pass        done with no mismatches
//   err_cnt     number of mismatching vectors this sweep
//   fail_vec    first mismatching vector, valid when fail_valid
//   fail_valid  at least one mismatch recorded this sweep
//   fail_mask   (CHECKER_FAIL_MASK_EN only) bit i set when vector i mismatched
//
// Build option: define CHECKER_FAIL_MASK_EN to add the fail_mask port.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// SETTLE | holding stim while the gate output settles
// SAMPLE | comparing dut_y against the golden value for one cycle
// DONE   | sweep finished, results held, waiting for start

module gate_truth_checker #(
    parameter int N_IN       = 2,
    parameter int SETTLE_CYC = 2,
    parameter int GATE_OP    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [N_IN-1:0]      stim,
    input  logic                 dut_y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_cnt,
    output logic [N_IN-1:0]      fail_vec,
    output logic                 fail_valid
`ifdef CHECKER_FAIL_MASK_EN
    ,
    output logic [(1<<N_IN)-1:0] fail_mask
`endif
);

    localparam int                CNT_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0]   STIM_LAST  = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [N_IN:0]     err_cnt_q, err_cnt_d;
    logic [N_IN-1:0]   fail_vec_q, fail_vec_d;
    logic              fail_valid_q, fail_valid_d;
`ifdef CHECKER_FAIL_MASK_EN
    logic [(1<<N_IN)-1:0] fail_mask_q, fail_mask_d;
`endif

    logic exp_y;
    logic mismatch;

    function automatic logic golden(input logic [N_IN-1:0] v);
        logic r;
        case (GATE_OP)
            0:       r = &v;
            1:       r = |v;
            2:       r = ^v;
            3:       r = ~&v;
            4:       r = ~|v;
            5:       r = ~^v;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        exp_y    = golden(stim_q);
        mismatch = (dut_y != exp_y);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stim_d       = stim_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_cnt_d    = err_cnt_q;
        fail_vec_d   = fail_vec_q;
        fail_valid_d = fail_valid_q;
`ifdef CHECKER_FAIL_MASK_EN
        fail_mask_d  = fail_mask_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    stim_d       = '0;
                    err_cnt_d    = '0;
                    fail_vec_d   = '0;
                    fail_valid_d = 1'b0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    busy_d       = 1'b1;
                    cnt_d        = CNT_RELOAD;
                    state_d      = S_SETTLE;
`ifdef CHECKER_FAIL_MASK_EN
                    fail_mask_d  = '0;
`endif
                end
            end

            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_SAMPLE: begin
                if (mismatch) begin
                    // at most V mismatches per sweep, so N_IN+1 bits never wrap
                    err_cnt_d = err_cnt_q + (N_IN+1)'(1);
                    if (!fail_valid_q) begin
                        fail_vec_d   = stim_q;
                        fail_valid_d = 1'b1;
                    end
`ifdef CHECKER_FAIL_MASK_EN
                    fail_mask_d[stim_q] = 1'b1;
`endif
                end
                if (stim_q == STIM_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    // err_cnt_q does not yet include this vector
                    pass_d  = !mismatch && (err_cnt_q == '0);
                end else begin
                    stim_d  = stim_q + N_IN'(1);
                    cnt_d   = CNT_RELOAD;
                    state_d = S_SETTLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            stim_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            fail_vec_q   <= '0;
            fail_valid_q <= 1'b0;
`ifdef CHECKER_FAIL_MASK_EN
            fail_mask_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stim_q       <= stim_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
            fail_vec_q   <= fail_vec_d;
            fail_valid_q <= fail_valid_d;
`ifdef CHECKER_FAIL_MASK_EN
            fail_mask_q  <= fail_mask_d;
`endif
        end
    end

    assign stim       = stim_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_cnt_q;
    assign fail_vec   = fail_vec_q;
    assign fail_valid = fail_valid_q;
`ifdef CHECKER_FAIL_MASK_EN
    assign fail_mask  = fail_mask_q;
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker (N_IN=2, SETTLE_CYC=2).
// u_dut checks an OR gate against a behavioural gate model selected by mode;
// u_nor checks a NOR gate whose output is tied high.

module tb_gate_truth_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start_nor;
    int         mode;           // 0 OR model, 1 tied 0, 2 AND model, 3 tied 1

    logic [1:0] stim;
    logic       dut_y;
    logic       busy, done, pass, fail_valid;
    logic [2:0] err_cnt;
    logic [1:0] fail_vec;

    logic [1:0] n_stim;
    logic       n_busy, n_done, n_pass, n_fail_valid;
    logic [2:0] n_err_cnt;
    logic [1:0] n_fail_vec;

`ifdef CHECKER_FAIL_MASK_EN
    logic [3:0] fail_mask;
    logic [3:0] n_fail_mask;
`endif

    int checks   = 0;
    int failures = 0;

    assign dut_y = (mode == 0) ? (stim[0] | stim[1]) :
                   (mode == 2) ? (stim[0] & stim[1]) :
                   (mode == 3) ? 1'b1 : 1'b0;

    always #5 clk = ~clk;

    gate_truth_checker #(.N_IN(2), .SETTLE_CYC(2), .GATE_OP(1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stim       (stim),
        .dut_y      (dut_y),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .fail_vec   (fail_vec),
        .fail_valid (fail_valid)
`ifdef CHECKER_FAIL_MASK_EN
        ,
        .fail_mask  (fail_mask)
`endif
    );

    gate_truth_checker #(.N_IN(2), .SETTLE_CYC(2), .GATE_OP(4)) u_nor (
        .clk        (clk),
        .rst        (rst),
        .start      (start_nor),
        .stim       (n_stim),
        .dut_y      (1'b1),
        .busy       (n_busy),
        .done       (n_done),
        .pass       (n_pass),
        .err_cnt    (n_err_cnt),
        .fail_vec   (n_fail_vec),
        .fail_valid (n_fail_valid)
`ifdef CHECKER_FAIL_MASK_EN
        ,
        .fail_mask  (n_fail_mask)
`endif
    );

    // Pulses start, then walks edges 1..12 checking stim/busy/done timing.
    // With stray=1 start is also pulsed before edges 3 and 7.
    task automatic run_sweep(input int stray, input string tag);
        logic [1:0] exp_stim;
        logic       exp_busy, exp_done;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (stim !== 2'd0 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s accept: stim=%0d busy=%0b done=%0b, required stim=0 busy=1 done=0",
                     tag, stim, busy, done);
        end
        for (int e = 1; e <= 12; e++) begin
            if (stray != 0 && (e == 3 || e == 7)) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            exp_stim = (e >= 9) ? 2'd3 : 2'(e / 3);
            exp_busy = (e < 12);
            exp_done = (e == 12);
            checks++;
            if (stim !== exp_stim || busy !== exp_busy || done !== exp_done) begin
                failures++;
                $display("FAIL %s edge %0d: stim=%0d busy=%0b done=%0b, required stim=%0d busy=%0b done=%0b",
                         tag, e, stim, busy, done, exp_stim, exp_busy, exp_done);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_nor = 1'b0; mode = 0;
        #12;
        checks++;
        if (stim !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
            err_cnt !== 3'd0 || fail_vec !== 2'd0 || fail_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_main: stim=%0d busy=%0b done=%0b pass=%0b err=%0d fv=%0d fvalid=%0b, required all 0",
                     stim, busy, done, pass, err_cnt, fail_vec, fail_valid);
        end
        checks++;
        if (n_stim !== 2'd0 || n_busy !== 1'b0 || n_done !== 1'b0 || n_pass !== 1'b0 ||
            n_err_cnt !== 3'd0 || n_fail_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_nor: stim=%0d busy=%0b done=%0b pass=%0b err=%0d fvalid=%0b, required all 0",
                     n_stim, n_busy, n_done, n_pass, n_err_cnt, n_fail_valid);
        end
`ifdef CHECKER_FAIL_MASK_EN
        checks++;
        if (fail_mask !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mask: got %b, required 0000", fail_mask);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_or_pass();
        mode = 0;
        run_sweep(0, "or_pass");
        checks++;
        if (pass !== 1'b1 || err_cnt !== 3'd0 || fail_valid !== 1'b0 || fail_vec !== 2'd0) begin
            failures++;
            $display("FAIL or_pass result: pass=%0b err=%0d fvalid=%0b fv=%0d, required 1 0 0 0",
                     pass, err_cnt, fail_valid, fail_vec);
        end
`ifdef CHECKER_FAIL_MASK_EN
        checks++;
        if (fail_mask !== 4'b0000) begin
            failures++;
            $display("FAIL or_pass mask: got %b, required 0000", fail_mask);
        end
`endif
    endtask

    task automatic test_tied_zero();
        mode = 1;
        run_sweep(0, "tied_zero");
        checks++;
        if (pass !== 1'b0 || err_cnt !== 3'd3 || fail_valid !== 1'b1 || fail_vec !== 2'd1) begin
            failures++;
            $display("FAIL tied_zero result: pass=%0b err=%0d fvalid=%0b fv=%0d, required 0 3 1 1",
                     pass, err_cnt, fail_valid, fail_vec);
        end
`ifdef CHECKER_FAIL_MASK_EN
        checks++;
        if (fail_mask !== 4'b1110) begin
            failures++;
            $display("FAIL tied_zero mask: got %b, required 1110", fail_mask);
        end
`endif
    endtask

    task automatic test_and_model();
        mode = 2;
        run_sweep(0, "and_model");
        checks++;
        if (pass !== 1'b0 || err_cnt !== 3'd2 || fail_valid !== 1'b1 || fail_vec !== 2'd1) begin
            failures++;
            $display("FAIL and_model result: pass=%0b err=%0d fvalid=%0b fv=%0d, required 0 2 1 1",
                     pass, err_cnt, fail_valid, fail_vec);
        end
`ifdef CHECKER_FAIL_MASK_EN
        checks++;
        if (fail_mask !== 4'b0110) begin
            failures++;
            $display("FAIL and_model mask: got %b, required 0110", fail_mask);
        end
`endif
    endtask

    task automatic test_nor_tied_one();
        start_nor = 1'b1;
        @(posedge clk); #1;
        start_nor = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (n_done !== 1'b1 || n_busy !== 1'b0 || n_pass !== 1'b0 || n_err_cnt !== 3'd3 ||
            n_fail_valid !== 1'b1 || n_fail_vec !== 2'd1) begin
            failures++;
            $display("FAIL nor_tied_one: done=%0b busy=%0b pass=%0b err=%0d fvalid=%0b fv=%0d, required 1 0 0 3 1 1",
                     n_done, n_busy, n_pass, n_err_cnt, n_fail_valid, n_fail_vec);
        end
`ifdef CHECKER_FAIL_MASK_EN
        checks++;
        if (n_fail_mask !== 4'b1110) begin
            failures++;
            $display("FAIL nor_tied_one mask: got %b, required 1110", n_fail_mask);
        end
`endif
    endtask

    task automatic test_reset_mid();
        mode = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (stim !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
            err_cnt !== 3'd0 || fail_vec !== 2'd0 || fail_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: stim=%0d busy=%0b done=%0b pass=%0b err=%0d fv=%0d fvalid=%0b, required all 0",
                     stim, busy, done, pass, err_cnt, fail_vec, fail_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        mode = 0;
        run_sweep(0, "after_reset");
        checks++;
        if (pass !== 1'b1 || err_cnt !== 3'd0 || fail_valid !== 1'b0) begin
            failures++;
            $display("FAIL after_reset result: pass=%0b err=%0d fvalid=%0b, required 1 0 0",
                     pass, err_cnt, fail_valid);
        end
    endtask

    task automatic test_start_ignored();
        mode = 0;
        run_sweep(1, "start_ignored");
        checks++;
        if (pass !== 1'b1 || err_cnt !== 3'd0 || fail_valid !== 1'b0) begin
            failures++;
            $display("FAIL start_ignored result: pass=%0b err=%0d fvalid=%0b, required 1 0 0",
                     pass, err_cnt, fail_valid);
        end
    endtask

    task automatic test_back_to_back();
        mode = 1;
        run_sweep(0, "b2b_first");
        mode = 0;
        start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || pass !== 1'b0 || err_cnt !== 3'd0 || fail_valid !== 1'b0 ||
            fail_vec !== 2'd0 || busy !== 1'b1 || stim !== 2'd0) begin
            failures++;
            $display("FAIL b2b_clear: done=%0b pass=%0b err=%0d fvalid=%0b fv=%0d busy=%0b stim=%0d, required 0 0 0 0 0 1 0",
                     done, pass, err_cnt, fail_valid, fail_vec, busy, stim);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            failures++;
            $display("FAIL b2b_held_done: done=%0b pass=%0b, required 1 1", done, pass);
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || stim !== 2'd0) begin
            failures++;
            $display("FAIL b2b_restart: done=%0b busy=%0b stim=%0d, required 0 1 0", done, busy, stim);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_done: done=%0b pass=%0b busy=%0b, required 1 1 0", done, pass, busy);
        end
    endtask

    initial begin
        test_reset();
        test_or_pass();
        test_tied_zero();
        test_and_model();
        test_nor_tied_one();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
